// File: rtl/de_morgan_check_seq.sv
// Clocked sweep controller: drives every input vector into two gate models and compares them.
// Optional STOP_ON_FAIL_EN: end the sweep at the first mismatch instead of finishing all vectors.
module de_morgan_check_seq #(
    parameter int unsigned N_IN        = 2,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec_o,
    input  logic            y_ref_i,
    input  logic            y_dut_i,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [7:0]      err_cnt,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_valid
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [7:0]      CNT_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    logic [1:0]      r_state, w_state_d;
    logic [7:0]      r_cnt, w_cnt_d;
    logic [N_IN-1:0] r_vec, w_vec_d;
    logic            r_busy, w_busy_d;
    logic            r_done, w_done_d;
    logic            r_pass, w_pass_d;
    logic [7:0]      r_err_cnt, w_err_cnt_d;
    logic [N_IN-1:0] r_fail_vec, w_fail_vec_d;
    logic            r_fail_valid, w_fail_valid_d;

    logic w_mismatch;
    logic w_last;
    logic w_stop;

    assign w_mismatch = y_ref_i ^ y_dut_i;
    assign w_last     = (r_vec == VEC_LAST);

`ifdef STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_vec_d        = r_vec;
        w_busy_d       = r_busy;
        w_done_d       = r_done;
        w_pass_d       = r_pass;
        w_err_cnt_d    = r_err_cnt;
        w_fail_vec_d   = r_fail_vec;
        w_fail_valid_d = r_fail_valid;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_d      = S_SETTLE;
                    w_vec_d        = '0;
                    w_cnt_d        = CNT_LOAD;
                    w_err_cnt_d    = '0;
                    w_fail_valid_d = 1'b0;
                    w_fail_vec_d   = '0;
                    w_pass_d       = 1'b0;
                    w_done_d       = 1'b0;
                    w_busy_d       = 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_cnt == 8'd0) begin
                    w_state_d = S_CHECK;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            S_CHECK: begin
                if (w_mismatch && (r_err_cnt != 8'hFF)) begin
                    w_err_cnt_d = r_err_cnt + 8'd1;
                end
                if (w_mismatch && !r_fail_valid) begin
                    w_fail_vec_d   = r_vec;
                    w_fail_valid_d = 1'b1;
                end
                if (w_last || w_stop) begin
                    w_state_d = S_DONE;
                    w_busy_d  = 1'b0;
                    w_done_d  = 1'b1;
                    // fail_valid is sticky for the sweep, so it stands for every earlier vector
                    w_pass_d  = !r_fail_valid && !w_mismatch;
                end else begin
                    w_state_d = S_SETTLE;
                    w_vec_d   = r_vec + N_IN'(1);
                    w_cnt_d   = CNT_LOAD;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_vec        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_fail_vec   <= '0;
            r_fail_valid <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_vec        <= w_vec_d;
            r_busy       <= w_busy_d;
            r_done       <= w_done_d;
            r_pass       <= w_pass_d;
            r_err_cnt    <= w_err_cnt_d;
            r_fail_vec   <= w_fail_vec_d;
            r_fail_valid <= w_fail_valid_d;
        end
    end

    assign vec_o      = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_cnt    = r_err_cnt;
    assign fail_vec   = r_fail_vec;
    assign fail_valid = r_fail_valid;

endmodule

// File: tb/tb_de_morgan_check_seq.sv
// Bench for de_morgan_check_seq: per-cycle comparison against a cycle-index model of the sweep,
// plus literal timing/result checks and a second N_IN=3, HOLD_CYCLES=1 instance.
module tb_de_morgan_check_seq;

    localparam int N  = 2;
    localparam int H  = 4;
    localparam int NV = 4;
    localparam int P  = H + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start;
    logic [N-1:0]  vec, fvec;
    logic          y_ref, y_dut, busy, done, pass, fvalid;
    logic [7:0]    err;
    logic [NV-1:0] tt;

    // reference is (NOT a) OR (NOT b); the gate under test is an arbitrary truth table
    assign y_ref = ~vec[0] | ~vec[1];
    assign y_dut = tt[vec];

    de_morgan_check_seq #(.N_IN(N), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_o(vec), .y_ref_i(y_ref),
        .y_dut_i(y_dut), .busy(busy), .done(done), .pass(pass), .err_cnt(err),
        .fail_vec(fvec), .fail_valid(fvalid)
    );

    logic       start3, y_ref3, y_dut3, busy3, done3, pass3, fvalid3;
    logic [2:0] vec3, fvec3;
    logic [7:0] err3;
    assign y_ref3 = |(~vec3);
    assign y_dut3 = ~(&vec3);

    de_morgan_check_seq #(.N_IN(3), .HOLD_CYCLES(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .vec_o(vec3), .y_ref_i(y_ref3),
        .y_dut_i(y_dut3), .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
        .fail_vec(fvec3), .fail_valid(fvalid3)
    );

    int total = 0;
    int bad   = 0;

    // model: -1 unknown, 0 idle, 1 sweeping (m_cyc = cycle index after start), 2 done
    int            m_mode = -1;
    int            m_cyc  = 0;
    logic [NV-1:0] m_tt   = '0;

    function automatic bit ref_of(int k);
        return !(((k & 1) != 0) && ((k & 2) != 0));
    endfunction

    function automatic bit mis(int k);
        return m_tt[k] != ref_of(k);
    endfunction

    function automatic int last_idx();
`ifdef STOP_ON_FAIL_EN
        for (int k = 0; k < NV; k++) if (mis(k)) return k;
`endif
        return NV - 1;
    endfunction

    always @(posedge clk) begin
        logic          s_start, s_rst;
        logic [N-1:0]  e_vec, e_fvec;
        logic          e_busy, e_done, e_pass, e_fvalid;
        logic [7:0]    e_err;
        s_start = start;
        s_rst   = rst_n;
        #1;
        if (!s_rst) m_mode = 0;
        else if (s_start && (m_mode == 0 || m_mode == 2)) begin
            m_mode = 1;
            m_cyc  = 1;
            m_tt   = tt;
        end else if (m_mode == 1) m_cyc++;
        if (m_mode == 1 && m_cyc >= (last_idx() + 1) * P + 1) m_mode = 2;

        e_vec = '0; e_fvec = '0; e_busy = 0; e_done = 0; e_pass = 0; e_fvalid = 0; e_err = '0;
        if (m_mode == 1) begin
            e_vec  = N'((m_cyc - 1) / P);
            e_busy = 1'b1;
            for (int k = 0; k < NV; k++) begin
                if ((k + 1) * P < m_cyc && mis(k)) begin
                    if (!e_fvalid) begin e_fvec = N'(k); e_fvalid = 1'b1; end
                    if (e_err != 8'hFF) e_err++;
                end
            end
        end else if (m_mode == 2) begin
            e_vec  = N'(last_idx());
            e_done = 1'b1;
            for (int k = 0; k <= last_idx(); k++) begin
                if (mis(k)) begin
                    if (!e_fvalid) begin e_fvec = N'(k); e_fvalid = 1'b1; end
                    if (e_err != 8'hFF) e_err++;
                end
            end
            e_pass = (e_err == 8'd0);
        end
        if (m_mode >= 0) begin
            total++;
            if ({vec, busy, done, pass, err, fvec, fvalid} !==
                {e_vec, e_busy, e_done, e_pass, e_err, e_fvec, e_fvalid}) begin
                bad++;
                $display("FAIL cycle_model t=%0t: got vec=%0d busy=%0b done=%0b pass=%0b err=%0d fvec=%0d fvalid=%0b expected vec=%0d busy=%0b done=%0b pass=%0b err=%0d fvec=%0d fvalid=%0b",
                         $time, vec, busy, done, pass, err, fvec, fvalid,
                         e_vec, e_busy, e_done, e_pass, e_err, e_fvec, e_fvalid);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    int vh[0:63];

    // Called just after a negedge; returns the cycle index (1 = cycle after start edge) of done.
    task automatic run_sweep(input int mid_start_cyc, input int rst_cyc, output int done_at);
        start   = 1'b1;
        done_at = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = 1'b0;
            rst_n = 1'b1;
            vh[c] = int'(vec);
            if (rst_cyc != 0 && c == rst_cyc + 1) begin
                check("reset_zero", int'({vec, busy, done, pass, err, fvec, fvalid}), 0);
                return;
            end
            if (done) begin done_at = c; return; end
            if (c == mid_start_cyc) start = 1'b1;
            if (c == rst_cyc) rst_n = 1'b0;
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic wait_done();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) return;
        end
        check("wait_done_timeout", 0, 1);
    endtask

    int d;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        tt     = 4'b0111;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({vec, busy, done, pass, err, fvec, fvalid}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // correct gate under test
        run_sweep(0, 0, d);
        check("ok_done_at", d, 21);
        check("ok_vec_c1", vh[1], 0);
        check("ok_vec_c6", vh[6], 1);
        check("ok_vec_c11", vh[11], 2);
        check("ok_vec_c16", vh[16], 3);
        check("ok_pass", int'(pass), 1);
        check("ok_err", int'(err), 0);
        check("ok_fvalid", int'(fvalid), 0);

        // NOR in place of NAND: vectors 1 and 2 disagree
        tt = 4'b0001;
        run_sweep(0, 0, d);
`ifdef STOP_ON_FAIL_EN
        check("nor_done_at", d, 11);
        check("nor_err", int'(err), 1);
        check("nor_vec", int'(vec), 1);
`else
        check("nor_done_at", d, 21);
        check("nor_err", int'(err), 2);
        check("nor_vec", int'(vec), 3);
`endif
        check("nor_pass", int'(pass), 0);
        check("nor_fvec", int'(fvec), 1);
        check("nor_fvalid", int'(fvalid), 1);

        // start mid-sweep must be ignored
        run_sweep(7, 0, d);
`ifdef STOP_ON_FAIL_EN
        check("midstart_done_at", d, 11);
`else
        check("midstart_done_at", d, 21);
`endif
        // restart from DONE clears results on the next cycle
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_clear", int'({vec, done, err, fvalid}), 0);
        check("restart_busy", int'(busy), 1);
        wait_done();

        // reset mid-sweep at cycle 12, then a full sweep
        tt = 4'b0111;
        run_sweep(0, 12, d);
        run_sweep(0, 0, d);
        check("post_reset_done_at", d, 21);
        check("post_reset_pass", int'(pass), 1);

        // random gate truth tables, checked every cycle by the model
        for (int i = 0; i < 8; i++) begin
            tt = NV'($urandom);
            run_sweep(0, 0, d);
        end

        // 3 inputs, one settle cycle per vector
        start3 = 1'b1;
        d = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (done3) begin d = c; break; end
        end
        check("n3_done_at", d, 17);
        check("n3_pass", int'(pass3), 1);
        check("n3_err", int'(err3), 0);
        check("n3_vec", int'(vec3), 7);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/de_morgan_check_seq.md
Name: de_morgan_check_seq

Overview:
- Self-checking sequencer for the De Morgan gate exercises.
- Walks every input combination into two gate implementations and holds each vector for a settle window. It then compares the reference output against the implementation under test.
- Reports pass/fail, a mismatch count and the first failing vector. This replaces hand-timed toggling stimulus with a clocked, repeatable controller that also fits on the lab board.

Parameters:
- N_IN, 2, number of gate inputs driven; the sweep covers all 2^N_IN vectors.
- HOLD_CYCLES, 4, settle cycles per vector before sampling; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a sweep; sampled in IDLE or DONE only.
- vec_o  output  N_IN  input vector driven to both gate implementations; bit 0 = a, bit 1 = b.
- y_ref_i  input  1  output of the reference implementation, combinational from vec_o.
- y_dut_i  input  1  output of the implementation under test, combinational from vec_o.
- busy  output  1  high in SETTLE and CHECK.
- done  output  1  high in DONE.
- pass  output  1  valid when done; 1 iff err_cnt==0.
- err_cnt  output  8  mismatch count, saturating at 255.
- fail_vec  output  N_IN  vector of the first mismatch.
- fail_valid  output  1  fail_vec holds a captured mismatch.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE.
  - vec_o=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, fail_valid=0.
  - Internal hold counter=0.
  - Reset takes effect mid-sweep and aborts the sweep.
- All outputs are registered.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE with start=1:
  - Next state SETTLE.
  - vec_o<=0, cnt<=HOLD_CYCLES-1.
  - err_cnt<=0, fail_valid<=0, fail_vec<=0, pass<=0, done<=0.
- SETTLE:
  - If cnt==0, go to CHECK; otherwise decrement cnt.
  - vec_o is stable throughout, giving exactly HOLD_CYCLES cycles in SETTLE per vector.
- CHECK (one cycle):
  - Compare y_ref_i with y_dut_i.
  - On mismatch: err_cnt increments unless it is already 255.
  - On mismatch with fail_valid==0: fail_vec<=vec_o and fail_valid<=1.
  - If vec_o == all ones (2^N_IN-1): go to DONE and set pass<=(no mismatch in the whole sweep, including this cycle).
  - Otherwise: vec_o<=vec_o+1, cnt<=HOLD_CYCLES-1, go to SETTLE.
- DONE:
  - done=1; vec_o keeps its last value; results hold.
  - start restarts the sweep; there is no automatic return to IDLE.
- start in SETTLE or CHECK is ignored; a sweep is never restarted mid-way.
- Latency:
  - Each vector takes HOLD_CYCLES+1 cycles.
  - done rises 1+2^N_IN*(HOLD_CYCLES+1) cycles after the edge that samples start.
  - With defaults this is 21 cycles.
- err_cnt width is fixed at 8 and saturates; it never wraps to 0.
- vec_o increment: the all-ones vector is always terminal, so the increment never wraps.

Optional Feature:
- Macro STOP_ON_FAIL_EN.
- When defined: a mismatch in CHECK sends the FSM directly to DONE with pass=0, skipping the remaining vectors. err_cnt is then 1 at DONE and vec_o equals fail_vec.
- When undefined: the sweep always completes all 2^N_IN vectors and err_cnt counts every mismatch.

Test Plan:
- Defaults, y_dut_i tied to a correct model (NOT(a AND b)) and y_ref_i to (NOT a) OR (NOT b); pulse start -> vec_o steps 0,1,2,3 every 5 cycles; done=1 at cycle 21 after start; pass=1, err_cnt=0, fail_valid=0.
- Faulty DUT (NOT(a OR b)), macro undefined -> mismatches at vectors 1 and 2; done at cycle 21, pass=0, err_cnt=2, fail_vec=2'b01, fail_valid=1.
- Same faulty DUT with STOP_ON_FAIL_EN defined -> done at cycle 11 (after the CHECK of vector 1); err_cnt=1, fail_vec=2'b01, vec_o=2'b01, pass=0.
- start pulsed again at cycle 7 mid-sweep -> ignored; done still at cycle 21; then start in DONE -> err_cnt, fail_valid and done clear the next cycle and vec_o=0.
- rst_n low for one edge at cycle 12 mid-sweep -> next cycle all outputs are zero and state is IDLE; start afterwards runs a full 21-cycle sweep.
- N_IN=3, HOLD_CYCLES=1, correct DUT -> 8 vectors at 2 cycles each; done at cycle 17; pass=1.
